// File: rtl/line_buffer_5tap.sv
// line_buffer_5tap: four-line raster buffer presenting a vertical 5-pixel column to the 5-tap cascade.
// Latency: 1 clock from in_pix/in_de/in_vs to pa..pe/out_de/out_vs.
// Backpressure: none; free-running stream, at most one pixel per clock, no stall input.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_vs, in_de       raster sync (rising in_vs = frame start) and data enable
//   in_pix             luma sample, valid while in_de=1
//   pa..pe             column taps, pa newest row .. pe four rows above
//   out_de, out_vs     in_de / in_vs delayed to match the taps
//   ovf                sticky: a line exceeded LINE_W pixels; cleared on frame start
//
// Build option: define LINE_BUFFER_EDGE_REPLICATE_EN to replicate the topmost
// valid row into missing taps at the top of a frame; otherwise they read as 0.
module line_buffer_5tap #(
  parameter int DATA_W = 8,
  parameter int LINE_W = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vs,
  input  logic              in_de,
  input  logic [DATA_W-1:0] in_pix,
  output logic [DATA_W-1:0] pa,
  output logic [DATA_W-1:0] pb,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pd,
  output logic [DATA_W-1:0] pe,
  output logic              out_de,
  output logic              out_vs,
  output logic              ovf
);

  // col is one bit wider than the address so it can sit at LINE_W on overflow.
  localparam logic [ADDR_W:0] COL_END = (ADDR_W+1)'(LINE_W);

  logic [DATA_W-1:0] l1 [0:LINE_W-1];
  logic [DATA_W-1:0] l2 [0:LINE_W-1];
  logic [DATA_W-1:0] l3 [0:LINE_W-1];
  logic [DATA_W-1:0] l4 [0:LINE_W-1];

  logic [ADDR_W:0]   col;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        lines_seen;
  logic              de_d, vs_d;
  logic              line_void;   // current line started mid-way (reset or vs inside de); do not count it
  logic [DATA_W-1:0] rd1, rd2, rd3, rd4;
  logic [DATA_W-1:0] pa_q, q1, q2, q3, q4;
  logic [2:0]        ls_q;        // lines_seen captured with the pixel, so taps stay stable while de is low
  logic              zero_q;      // last captured pixel was an overflow pixel
  logic              vs_rise, eol, in_room, pix_wr;
  logic [DATA_W-1:0] t1, t2, t3, t4;

  assign addr    = col[ADDR_W-1:0];
  assign vs_rise = in_vs & ~vs_d;
  assign eol     = ~in_de & de_d;
  assign in_room = (col < COL_END);
  assign pix_wr  = in_de & in_room;

  // Read-first: the cascade writes each RAM with the value the previous RAM held before this edge.
  assign rd1 = l1[addr];
  assign rd2 = l2[addr];
  assign rd3 = l3[addr];
  assign rd4 = l4[addr];

  // Line memories carry no reset; stale rows are hidden by the lines_seen mask.
  always_ff @(posedge clk) begin
    if (!rst && pix_wr) begin
      l1[addr] <= in_pix;
      l2[addr] <= rd1;
      l3[addr] <= rd2;
      l4[addr] <= rd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      lines_seen <= '0;
      de_d       <= 1'b0;
      vs_d       <= 1'b0;
      ovf        <= 1'b0;
      line_void  <= in_de;
      pa_q       <= '0;
      q1         <= '0;
      q2         <= '0;
      q3         <= '0;
      q4         <= '0;
      ls_q       <= '0;
      zero_q     <= 1'b0;
    end else begin
      de_d <= in_de;
      vs_d <= in_vs;

      if (vs_rise) begin
        col        <= '0;
        lines_seen <= '0;
        ovf        <= 1'b0;
        line_void  <= in_de;
      end else begin
        if (eol) begin
          col <= '0;
          if (!line_void && lines_seen != 3'd4)
            lines_seen <= lines_seen + 3'd1;
        end else if (pix_wr) begin
          col <= col + 1'b1;
        end
        if (!in_de)
          line_void <= 1'b0;
        if (in_de && !in_room)
          ovf <= 1'b1;
      end

      // Tap registers only move on active pixels; they hold across blanking.
      if (in_de) begin
        if (in_room) begin
          pa_q   <= in_pix;
          q1     <= rd1;
          q2     <= rd2;
          q3     <= rd3;
          q4     <= rd4;
          ls_q   <= lines_seen;
          zero_q <= 1'b0;
        end else begin
          zero_q <= 1'b1;
        end
      end
    end
  end

  // Top-of-frame masking: tap k needs at least k completed lines in this frame.
  always_comb begin
`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
    t1 = (ls_q >= 3'd1) ? q1 : pa_q;
    t2 = (ls_q >= 3'd2) ? q2 : t1;
    t3 = (ls_q >= 3'd3) ? q3 : t2;
    t4 = (ls_q >= 3'd4) ? q4 : t3;
`else
    t1 = (ls_q >= 3'd1) ? q1 : '0;
    t2 = (ls_q >= 3'd2) ? q2 : '0;
    t3 = (ls_q >= 3'd3) ? q3 : '0;
    t4 = (ls_q >= 3'd4) ? q4 : '0;
`endif
    pa = pa_q;
    pb = t1;
    pc = t2;
    pd = t3;
    pe = t4;
    if (zero_q) begin
      pa = '0;
      pb = '0;
      pc = '0;
      pd = '0;
      pe = '0;
    end
  end

  assign out_de = de_d;
  assign out_vs = vs_d;

endmodule

// File: tb/tb_line_buffer_5tap.sv
// tb_line_buffer_5tap: directed-vector bench for line_buffer_5tap with LINE_W=8.
// Latency: inputs driven just after a rising edge, outputs sampled 1 ns after the next one.
// Backpressure: none; the stream is driven one step per clock.
module tb_line_buffer_5tap;

`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, in_vs, in_de;
  logic [7:0] in_pix;
  logic [7:0] pa, pb, pc, pd, pe;
  logic       out_de, out_vs, ovf;

  int n_cmp = 0;
  int n_err = 0;

  line_buffer_5tap #(.DATA_W(8), .LINE_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .in_vs(in_vs), .in_de(in_de), .in_pix(in_pix),
    .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pe(pe),
    .out_de(out_de), .out_vs(out_vs), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic v, input logic d, input logic [7:0] p);
    rst = r; in_vs = v; in_de = d; in_pix = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gap(input int n);
    for (int g = 0; g < n; g++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; in_vs = 1'b0; in_de = 1'b0; in_pix = 8'h00;

    // Reset, three idle cycles
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rst_pa", pa, 8'h00);
    chk("rst_pb", pb, 8'h00);
    chk("rst_pc", pc, 8'h00);
    chk("rst_pd", pd, 8'h00);
    chk("rst_pe", pe, 8'h00);
    chk("rst_de", {7'd0, out_de}, 8'h00);
    chk("rst_vs", {7'd0, out_vs}, 8'h00);
    chk("rst_ovf", {7'd0, ovf}, 8'h00);

    // Frame 1: six lines of 8 pixels, value = line*16+col
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("vs_dly1", {7'd0, out_vs}, 8'h01);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("vs_dly0", {7'd0, out_vs}, 8'h00);
    for (int l = 0; l < 6; l++) begin
      for (int c = 0; c < 8; c++) begin
        step(1'b0, 1'b0, 1'b1, 8'(l*16 + c));
        if (l == 0 && c == 0) chk("de_dly1", {7'd0, out_de}, 8'h01);
        if (l == 1 && c == 2) begin
          chk("l1c2_pa", pa, 8'h12);
          chk("l1c2_pb", pb, 8'h02);
          chk("l1c2_pc", pc, REP ? 8'h02 : 8'h00);
          chk("l1c2_pd", pd, REP ? 8'h02 : 8'h00);
          chk("l1c2_pe", pe, REP ? 8'h02 : 8'h00);
        end
        if (l == 5 && c == 3) begin
          chk("l5c3_pa", pa, 8'h53);
          chk("l5c3_pb", pb, 8'h43);
          chk("l5c3_pc", pc, 8'h33);
          chk("l5c3_pd", pd, 8'h23);
          chk("l5c3_pe", pe, 8'h13);
          chk("l5c3_de", {7'd0, out_de}, 8'h01);
        end
      end
      step(1'b0, 1'b0, 1'b0, 8'h00);
      if (l == 5) begin
        chk("eol_de", {7'd0, out_de}, 8'h00);
        chk("eol_hold_pa", pa, 8'h57);
        chk("eol_hold_pe", pe, 8'h17);
      end
      gap(3);
    end

    // Frame 2: one line, 20-cycle blanking, second line
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(c));
    gap(20);
    chk("blank_pa", pa, 8'hA7);
    chk("blank_pb", pb, REP ? 8'hA7 : 8'h00);
    chk("blank_de", {7'd0, out_de}, 8'h00);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b0, 1'b1, 8'hB0 + 8'(c));
      if (c == 0) begin
        chk("lb_c0_pb", pb, 8'hA0);
        chk("lb_c0_pc", pc, REP ? 8'hA0 : 8'h00);
      end
      if (c == 3) chk("lb_c3_pb", pb, 8'hA3);
    end
    gap(4);

    // Overflow: 10 pixels into an 8-deep line
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, 1'b1, 8'hD0 + 8'(c));
      if (c == 7) begin
        chk("ov_c7_pa", pa, 8'hD7);
        chk("ov_c7_pb", pb, 8'hB7);
        chk("ov_c7_ovf", {7'd0, ovf}, 8'h00);
      end
      if (c == 8) begin
        chk("ov_c8_pa", pa, 8'h00);
        chk("ov_c8_pb", pb, 8'h00);
        chk("ov_c8_pe", pe, 8'h00);
        chk("ov_c8_ovf", {7'd0, ovf}, 8'h01);
        chk("ov_c8_de", {7'd0, out_de}, 8'h01);
      end
      if (c == 9) chk("ov_c9_pa", pa, 8'h00);
    end
    gap(4);
    chk("ovf_sticky", {7'd0, ovf}, 8'h01);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("ovf_clr", {7'd0, ovf}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Frame 3: reset in the middle of line 2, then two more lines
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b1, 8'(l*16 + c));
      gap(4);
    end
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b1, 8'h20 + 8'(c));
    step(1'b1, 1'b0, 1'b1, 8'h24);
    chk("mrst_pa", pa, 8'h00);
    chk("mrst_pb", pb, 8'h00);
    chk("mrst_de", {7'd0, out_de}, 8'h00);
    for (int c = 5; c < 8; c++) begin
      step(1'b0, 1'b0, 1'b1, 8'h20 + 8'(c));
      if (c == 5) begin
        chk("post_rst_pa", pa, 8'h25);
        chk("post_rst_pb", pb, REP ? 8'h25 : 8'h00);
      end
    end
    gap(4);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b0, 1'b1, 8'h30 + 8'(c));
      if (c == 1) begin
        chk("l3_pa", pa, 8'h31);
        chk("l3_pb", pb, REP ? 8'h31 : 8'h00);
      end
    end
    gap(4);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b0, 1'b1, 8'h40 + 8'(c));
      if (c == 1) begin
        chk("l4_pb", pb, 8'h31);
        chk("l4_pc", pc, REP ? 8'h31 : 8'h00);
      end
    end
    gap(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
